// File: rtl/timer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// timer_ctrl_pkg
//   Shared definitions for the timer_ctrl block: FSM state codes, counter
//   width, terminal values for each direction, prescaler width and the
//   default prescaler divide ratio.
//
//   Optional feature macro used by the block: TIMER_CTRL_AUTORELOAD_EN
// -----------------------------------------------------------------------------
package timer_ctrl_pkg;

  // FSM state codes; these values are visible externally on oState.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } stateT;

  localparam int unsigned COUNT_W = 4;

  // Counting stops at these values; the counter never wraps around.
  localparam logic [COUNT_W-1:0] TERM_DOWN = 4'd0;
  localparam logic [COUNT_W-1:0] TERM_UP   = 4'd15;

  // The prescaler must hold DIV-1 for the largest legal DIV (1023).
  localparam int unsigned PRESC_W     = 10;
  localparam int unsigned DIV_DEFAULT = 10;

  // Terminal value for a given run direction (1 = up).
  function automatic logic [COUNT_W-1:0] terminalValue(input logic up);
    return up ? TERM_UP : TERM_DOWN;
  endfunction

endpackage : timer_ctrl_pkg

// File: rtl/timer_ctrl_count_core.sv
// -----------------------------------------------------------------------------
// count_core
//   Loadable 4-bit up/down counter used as the timer_ctrl datapath.
//   Load has priority over a step; a step moves the value by one in the
//   direction given by iUp. Range limiting is the caller's job: the FSM
//   never enables a step while the value sits at its terminal value.
//
// Ports
//   iClk     rising-edge clock
//   inReset  synchronous active-low reset (clears the count)
//   iLoad    load iData on this edge
//   iEnable  step by one on this edge
//   iUp      step direction, 1 = increment, 0 = decrement
//   iData    value loaded when iLoad is high
//   oCount   current counter value
// -----------------------------------------------------------------------------
module count_core
  import timer_ctrl_pkg::*;
(
  input  logic               iClk,
  input  logic               inReset,
  input  logic               iLoad,
  input  logic               iEnable,
  input  logic               iUp,
  input  logic [COUNT_W-1:0] iData,
  output logic [COUNT_W-1:0] oCount
);

  // NOTE: state registers use non-blocking assignments so every register in
  // the design samples the pre-edge values, independent of process order.
  always_ff @(posedge iClk) begin
    if (!inReset) begin
      oCount <= '0;
    end else if (iLoad) begin
      oCount <= iData;
    end else if (iEnable) begin
      oCount <= iUp ? oCount + COUNT_W'(1) : oCount - COUNT_W'(1);
    end
  end

endmodule : count_core

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//   Prescaled 4-bit one-shot timer. A start request loads the preset and the
//   direction, then the counter steps once every DIV clock cycles until it
//   reaches its terminal value (0 counting down, 15 counting up), where the
//   FSM parks in DONE until acknowledged or restarted. A level-sensitive
//   pause freezes both the prescaler and the count.
//
//   Optional feature: define TIMER_CTRL_AUTORELOAD_EN to add the iAuto input.
//   With iAuto=1 the timer reloads the preset instead of stopping, pulsing
//   oDone for one cycle at each terminal. Without the macro the port is
//   absent and operation is one-shot only.
//
// Parameters
//   DIV      clock cycles per counter step, legal range 1..1023
//
// Ports
//   iClk     rising-edge clock
//   inReset  synchronous active-low reset, overrides every other input
//   iStart   start request (IDLE or DONE only)
//   iPause   level-sensitive hold while running
//   iUp      direction sampled in LOAD: 1 = up, 0 = down
//   iPreset  start value sampled in LOAD
//   iAck     clears DONE back to IDLE
//   iAuto    auto-reload enable (only with TIMER_CTRL_AUTORELOAD_EN)
//   oCount   current counter value
//   oBusy    high in LOAD, RUN or PAUSE
//   oDone    completion flag
//   oTick    high for the cycle following each counter step
//   oState   FSM state code (see timer_ctrl_pkg::stateT)
// -----------------------------------------------------------------------------
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic               iClk,
  input  logic               inReset,
  input  logic               iStart,
  input  logic               iPause,
  input  logic               iUp,
  input  logic [COUNT_W-1:0] iPreset,
  input  logic               iAck,
`ifdef TIMER_CTRL_AUTORELOAD_EN
  input  logic               iAuto,
`endif
  output logic [COUNT_W-1:0] oCount,
  output logic               oBusy,
  output logic               oDone,
  output logic               oTick,
  output logic [2:0]         oState
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  stateT              state;
  stateT              nextState;
  logic               dirUp;       // direction latched in LOAD
  logic [PRESC_W-1:0] presc;       // RUN edges since the last step
  logic               tickPulse;   // registered step strobe
  logic               autoDone;    // one-cycle done flag on auto-reload
  logic               autoEn;

  // Decoded controls from the FSM.
  logic loadCount;
  logic prescAdvance;
  logic tickNow;
  logic autoReload;
  logic atTerminal;

`ifdef TIMER_CTRL_AUTORELOAD_EN
  assign autoEn = iAuto;
`else
  assign autoEn = 1'b0;
`endif

  // Terminal detection looks at the latched direction, never at iUp, so
  // changing iUp mid-run has no effect.
  assign atTerminal = (oCount == terminalValue(dirUp));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (!inReset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    nextState    = state;
    loadCount    = 1'b0;
    prescAdvance = 1'b0;
    tickNow      = 1'b0;
    autoReload   = 1'b0;

    unique case (state)
      IDLE: begin
        if (iStart) nextState = LOAD;
      end

      LOAD: begin
        loadCount = 1'b1;
        nextState = RUN;
      end

      RUN: begin
        // Terminal check comes first: it beats a simultaneous pause and it
        // suppresses the step, so the count never wraps.
        if (atTerminal) begin
          if (autoEn) begin
            autoReload = 1'b1;
            nextState  = LOAD;
          end else begin
            nextState  = DONE;
          end
        end else if (iPause) begin
          nextState = PAUSE;
        end else begin
          prescAdvance = 1'b1;
          tickNow      = (presc == PRESC_LAST);
        end
      end

      PAUSE: begin
        // Returning to RUN does not advance the prescaler; counting picks up
        // from the frozen value on the following RUN edge.
        if (!iPause) nextState = RUN;
      end

      DONE: begin
        if (iStart) begin
          nextState = LOAD;
        end else if (iAck) begin
          nextState = IDLE;
        end
      end

      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Prescaler, direction latch and strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (!inReset) begin
      presc     <= '0;
      dirUp     <= 1'b1;
      tickPulse <= 1'b0;
      autoDone  <= 1'b0;
    end else begin
      tickPulse <= tickNow;
      autoDone  <= autoReload;
      if (loadCount) begin
        presc <= '0;
        dirUp <= iUp;
      end else if (prescAdvance) begin
        presc <= tickNow ? '0 : presc + PRESC_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counter datapath
  // ---------------------------------------------------------------------------
  count_core uCore (
    .iClk    (iClk),
    .inReset (inReset),
    .iLoad   (loadCount),
    .iEnable (tickNow),
    .iUp     (dirUp),
    .iData   (iPreset),
    .oCount  (oCount)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign oState = state;
  assign oBusy  = state inside {LOAD, RUN, PAUSE};
  assign oDone  = (state == DONE) || autoDone;
  assign oTick  = tickPulse;

endmodule : timer_ctrl
